serial_mag_comparator: RTL and testbench

- Bit-serial unsigned magnitude comparator for WIDTH-bit operands.
- Captures a_in/b_in on a start strobe, then walks the operand bits MSB-first, one bit per clock, through a single comparator_1bit instance.
- Stops early at the first differing bit and registers greater/equal/less flags with a one-cycle done pulse.
- Sits upstream of the flag consumers: the sequential wrapper that feeds the existing 1-bit comparator.

---
 rtl/serial_cmp_pkg.sv | 23 ++
 rtl/serial_mag_comparator_bit.sv | 15 +
 rtl/serial_mag_comparator.sv | 122 ++++++++++++
 tb/tb_serial_mag_comparator.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: FSM state
// encoding and the helper used to size the bit counter.
package serial_cmp_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_COMPARE = 1'b1
   } state_e;

   // Number of bits needed to hold values 0..value-1.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/serial_mag_comparator_bit.sv
// Existing single-bit magnitude comparator; evaluated on the current operand
// MSBs by the serial wrapper.
module comparator_1bit (
   input  logic a_in,
   input  logic b_in,
   output logic g_out,
   output logic e_out,
   output logic l_out
);

   assign g_out = a_in & ~b_in;
   assign e_out = ~(a_in ^ b_in);
   assign l_out = ~a_in & b_in;

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator: walks the captured operands
// MSB-first and stops at the first differing bit.
module serial_mag_comparator
   import serial_cmp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             start_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy_out,
   output logic             done_out,
   output logic             g_out,
   output logic             e_out,
   output logic             l_out
);

   localparam int CNT_W = clog2(WIDTH + 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   aSr_q, aSr_d;
   logic [WIDTH-1:0]   bSr_q, bSr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               g_q, g_d;
   logic               e_q, e_d;
   logic               l_q, l_d;

   logic               bitGt;
   logic               bitEq;
   logic               bitLt;

   comparator_1bit u_bit (
      .a_in  (aSr_q[WIDTH-1]),
      .b_in  (bSr_q[WIDTH-1]),
      .g_out (bitGt),
      .e_out (bitEq),
      .l_out (bitLt)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= ST_IDLE;
         aSr_q   <= '0;
         bSr_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         g_q     <= 1'b0;
         e_q     <= 1'b0;
         l_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         aSr_q   <= aSr_d;
         bSr_q   <= bSr_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         g_q     <= g_d;
         e_q     <= e_d;
         l_q     <= l_d;
      end
   end

   // Result flags hold their value until the next accepted start clears them.
   always_comb begin
      state_d = state_q;
      aSr_d   = aSr_q;
      bSr_d   = bSr_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      g_d     = g_q;
      e_d     = e_q;
      l_d     = l_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_in) begin
               aSr_d   = a_in;
               bSr_d   = b_in;
               cnt_d   = CNT_W'(WIDTH);
               g_d     = 1'b0;
               e_d     = 1'b0;
               l_d     = 1'b0;
               busy_d  = 1'b1;
               state_d = ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            if (!bitEq) begin
               g_d     = bitGt;
               l_d     = bitLt;
               e_d     = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_W'(1)) begin
               e_d     = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               aSr_d = aSr_q << 1;
               bSr_d = bSr_q << 1;
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy_out = busy_q;
   assign done_out = done_q;
   assign g_out    = g_q;
   assign e_out    = e_q;
   assign l_out    = l_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench for serial_mag_comparator: the driver pushes the expected
// flags and decision latency, a monitor pops and checks on every done pulse.
module tb_serial_mag_comparator;

   localparam int W = 8;

   typedef struct {
      logic [2:0] gel;
      int         k;
      int         acceptCycle;
   } exp_t;

   logic         clk_in;
   logic         rst_n_in;
   logic         start_in;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         busy_out;
   logic         done_out;
   logic         g_out;
   logic         e_out;
   logic         l_out;

   exp_t         sb[$];
   logic [2:0]   lastGel;
   int           cycle;
   int           passCount;
   int           totalCount;

   serial_mag_comparator #(.WIDTH(W)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .start_in (start_in),
      .a_in     (a_in),
      .b_in     (b_in),
      .busy_out (busy_out),
      .done_out (done_out),
      .g_out    (g_out),
      .e_out    (e_out),
      .l_out    (l_out)
   );

   // Free-running clock and cycle counter used to time decisions.
   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   initial cycle = 0;
   always @(posedge clk_in) cycle <= cycle + 1;

   // Reference model: ordering from plain integer comparison, decision edge
   // from the highest set bit of a XOR b.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t r;
      logic [W-1:0] diff;
      r.gel = {(a > b), (a == b), (a < b)};
      r.k = W;
      r.acceptCycle = 0;
      diff = a ^ b;
      for (int i = 0; i < W; i++)
         if (diff[i]) r.k = W - i;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      totalCount++;
      if (actual === required) passCount++;
      else $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, actual, required, cycle);
   endtask

   // Monitor: checks every cycle out of reset, against the scoreboard front.
   always @(negedge clk_in) begin
      if (rst_n_in) begin
         if (done_out) begin
            if (sb.size() == 0) begin
               checkOutput("unexpectedDone", 32'(done_out), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               checkOutput("flags", 32'({g_out, e_out, l_out}), 32'(e.gel));
               checkOutput("latency", 32'(cycle - e.acceptCycle), 32'(e.k));
               checkOutput("busyAtDone", 32'(busy_out), 32'd0);
               lastGel = e.gel;
            end
         end else if (sb.size() != 0) begin
            if (cycle > sb[0].acceptCycle + sb[0].k) begin
               checkOutput("doneTimeout", 32'(cycle - sb[0].acceptCycle), 32'(sb[0].k));
               void'(sb.pop_front());
            end else begin
               checkOutput("busyNoFlags", 32'({busy_out, g_out, e_out, l_out}), 32'b1000);
            end
         end else begin
            checkOutput("idleHold", 32'({busy_out, g_out, e_out, l_out}), 32'({1'b0, lastGel}));
         end
      end
   end

   // One compare; optionally pulses a bogus start mid-operation. Returns just
   // after the decision edge so a following call issues a back-to-back start.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit pulseMid);
      exp_t e;
      @(negedge clk_in);
      start_in = 1'b1;
      a_in = a;
      b_in = b;
      @(posedge clk_in);
      #1;
      e = model(a, b);
      e.acceptCycle = cycle;
      sb.push_back(e);
      @(negedge clk_in);
      start_in = 1'b0;
      a_in = W'($urandom);
      b_in = W'($urandom);
      if (pulseMid && e.k >= 3) begin
         @(posedge clk_in);
         @(negedge clk_in);
         start_in = 1'b1;
         a_in = ~a;
         b_in = ~b;
         @(posedge clk_in);
         @(negedge clk_in);
         start_in = 1'b0;
         repeat (e.k - 2) @(posedge clk_in);
      end else begin
         repeat (e.k) @(posedge clk_in);
      end
   endtask

   // Start held high: a new compare is accepted each time the DUT returns idle.
   task automatic heldStart(input logic [W-1:0] a, input logic [W-1:0] b, input int n);
      exp_t e;
      e = model(a, b);
      @(negedge clk_in);
      start_in = 1'b1;
      a_in = a;
      b_in = b;
      for (int i = 0; i < n; i++) begin
         @(posedge clk_in);
         #1;
         e.acceptCycle = cycle;
         sb.push_back(e);
         repeat (e.k) @(posedge clk_in);
      end
      @(negedge clk_in);
      start_in = 1'b0;
   endtask

   task automatic resetAbort();
      @(negedge clk_in);
      start_in = 1'b1;
      a_in = '0;
      b_in = '0;
      @(posedge clk_in);
      #1;
      begin
         exp_t e;
         e = model('0, '0);
         e.acceptCycle = cycle;
         sb.push_back(e);
      end
      @(negedge clk_in);
      start_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #2;
      rst_n_in = 1'b0;
      #1;
      checkOutput("abortOutputs", 32'({busy_out, done_out, g_out, e_out, l_out}), 32'd0);
      sb.delete();
      lastGel = 3'b000;
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      passCount  = 0;
      totalCount = 0;
      lastGel    = 3'b000;
      rst_n_in   = 1'b0;
      start_in   = 1'b0;
      a_in       = '0;
      b_in       = '0;
      repeat (3) @(negedge clk_in);
      checkOutput("resetOutputs", 32'({busy_out, done_out, g_out, e_out, l_out}), 32'd0);
      rst_n_in = 1'b1;
      repeat (2) @(negedge clk_in);

      applyStimulus(8'hA5, 8'hA5, 1'b0);
      applyStimulus(8'h80, 8'h7F, 1'b0);
      applyStimulus(8'h40, 8'h60, 1'b0);
      applyStimulus(8'h12, 8'h13, 1'b0);
      repeat (2) @(negedge clk_in);
      applyStimulus(8'h01, 8'h00, 1'b1);
      resetAbort();
      applyStimulus(8'hFF, 8'hFE, 1'b0);
      heldStart(8'hF0, 8'h0F, 4);
      repeat (2) @(negedge clk_in);
      applyStimulus(8'h00, 8'h00, 1'b1);
      applyStimulus(8'hFF, 8'hFF, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         a = W'($urandom);
         case ($urandom_range(0, 3))
            0: b = a;
            1: b = a ^ W'(1 << $urandom_range(0, W - 1));
            default: b = W'($urandom);
         endcase
         applyStimulus(a, b, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(negedge clk_in);
      end

      repeat (W + 4) @(negedge clk_in);
      checkOutput("scoreboardEmpty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
